// File: rtl/instr_fetch_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_loader_pkg
// Brief    : Opcodes, NOP word and state encodings shared by the fetch loader.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_loader_pkg;

  localparam int INSTR_W = 20;

  localparam logic [3:0] OP_NULL = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_MOV  = 4'h4;

  localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NULL, 16'h0000};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_loader_prog_ram.sv
`default_nettype none
// ============================================================================
// Module   : prog_ram
// Brief    : DEPTH x WIDTH program store, synchronous write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module prog_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 20
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= r_mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_loader
// Brief    : Loadable program RAM plus pc sequencer feeding the processor core.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_loader
  import instr_fetch_loader_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               start,
  input  logic               hold,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W:0]    prog_len,
  output logic [1:0]         state_o,
  output logic               load_err
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W:0]     r_prog_len;
  logic                r_load_err;
  logic                r_instr_valid;
  logic [INSTR_W-1:0]  w_ram_rdata;
  logic [ADDR_W-1:0]   w_fetch_addr;
  logic                w_accept;
  logic                w_ptr_full;
  logic                w_last_shown;
  logic                w_enter_load;
  logic                w_enter_run;
  logic                w_fetch;
  logic                w_halt;

  assign load_ready   = (r_state == ST_LOAD);
  assign w_accept     = load_valid && load_ready;
  assign w_ptr_full   = (r_wr_ptr == ADDR_W'(DEPTH - 1));
  // The word on the output is the final one once pc reaches prog_len-1.
  assign w_last_shown = r_instr_valid && ({1'b0, r_pc} == (r_prog_len - (ADDR_W+1)'(1)));
  assign w_fetch_addr = r_instr_valid ? (r_pc + ADDR_W'(1)) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_enter_load = 1'b0;
    w_enter_run  = 1'b0;
    w_fetch      = 1'b0;
    w_halt       = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (load_req) begin
          w_state_nxt  = ST_LOAD;
          w_enter_load = 1'b1;
        end else if (start && (r_prog_len != '0)) begin
          w_state_nxt = ST_RUN;
          w_enter_run = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_accept && (load_last || w_ptr_full)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          if (w_last_shown) begin
            w_state_nxt = ST_HALT;
            w_halt      = 1'b1;
          end else begin
            w_fetch = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_pc          <= '0;
      r_prog_len    <= '0;
      r_load_err    <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      if (w_enter_load) begin
        r_wr_ptr   <= '0;
        r_prog_len <= '0;
        r_load_err <= 1'b0;
      end
      if (w_accept) begin
        if (load_last) begin
          r_prog_len <= {1'b0, r_wr_ptr} + (ADDR_W+1)'(1);
        end else if (w_ptr_full) begin
          r_prog_len <= c_depth;
          r_load_err <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        end
      end
      if (w_enter_run) begin
        r_pc          <= '0;
        r_instr_valid <= 1'b0;
      end
      if (w_fetch) begin
        r_pc          <= w_fetch_addr;
        r_instr_valid <= 1'b1;
      end
      if (w_halt) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  prog_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (INSTR_W)
  ) u_prog_ram (
    .clk   (clk),
    .we    (w_accept),
    .waddr (r_wr_ptr),
    .wdata (load_data),
    .re    (w_fetch),
    .raddr (w_fetch_addr),
    .rdata (w_ram_rdata)
  );

  // The RAM read register carries the word; the valid flag gates in NOP.
  assign instruction = r_instr_valid ? w_ram_rdata : NOP_WORD;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign prog_len    = r_prog_len;
  assign state_o     = r_state;
  assign load_err    = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_loader
// Brief    : Directed self-checking bench for instr_fetch_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_loader;

  localparam int c_w = 20;

  logic           clk = 1'b0;
  logic           reset;
  logic           load_req;
  logic           load_valid;
  logic [c_w-1:0] load_data;
  logic           load_last;
  logic           load_ready;
  logic           start;
  logic           hold;
  logic [c_w-1:0] instruction;
  logic           instr_valid;
  logic [3:0]     pc;
  logic [4:0]     prog_len;
  logic [1:0]     state_o;
  logic           load_err;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [c_w-1:0] c_nop = 20'h00000;
  localparam logic [c_w-1:0] c_a   = 20'h1_0102;
  localparam logic [c_w-1:0] c_b   = 20'h2_0304;
  localparam logic [c_w-1:0] c_c   = 20'h3_0506;
  localparam logic [c_w-1:0] c_a2  = 20'h4_1111;
  localparam logic [c_w-1:0] c_b2  = 20'h2_2222;
  localparam logic [c_w-1:0] c_c2  = 20'h3_3333;
  localparam logic [c_w-1:0] c_d2  = 20'h1_4444;
  localparam logic [c_w-1:0] c_bad = 20'hF_FFFF;

  always #5 clk = ~clk;

  instr_fetch_loader #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_req    (load_req),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .start       (start),
    .hold        (hold),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .prog_len    (prog_len),
    .state_o     (state_o),
    .load_err    (load_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [c_w-1:0] w, input logic [3:0] a);
    check({tag, " instr"}, 32'(instruction), 32'(w));
    check({tag, " valid"}, 32'(instr_valid), 32'd1);
    check({tag, " pc"}, 32'(pc), 32'(a));
  endtask

  task automatic load_word(input logic [c_w-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    cyc();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    load_req   = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    start      = 1'b0;
    hold       = 1'b0;

    // Reset held for three cycles.
    repeat (3) cyc();
    check("rst state", 32'(state_o), 32'd0);
    check("rst instr", 32'(instruction), 32'(c_nop));
    check("rst valid", 32'(instr_valid), 32'd0);
    check("rst pc", 32'(pc), 32'd0);
    check("rst len", 32'(prog_len), 32'd0);
    check("rst err", 32'(load_err), 32'd0);
    reset = 1'b1;
    cyc();

    // Start with an empty program is ignored.
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start empty state", 32'(state_o), 32'd0);

    // load_req wins over a simultaneous start.
    load_req = 1'b1;
    start    = 1'b1;
    cyc();
    load_req = 1'b0;
    start    = 1'b0;
    check("req+start state", 32'(state_o), 32'd1);
    check("load ready", 32'(load_ready), 32'd1);
    check("load instr nop", 32'(instruction), 32'(c_nop));

    // Three-word program A, B, C.
    load_word(c_a, 1'b0);
    load_word(c_b, 1'b0);
    load_word(c_c, 1'b1);
    check("3w state", 32'(state_o), 32'd0);
    check("3w len", 32'(prog_len), 32'd3);
    check("3w ready", 32'(load_ready), 32'd0);
    check("3w err", 32'(load_err), 32'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("run entry state", 32'(state_o), 32'd2);
    check("run entry valid", 32'(instr_valid), 32'd0);
    check("run entry pc", 32'(pc), 32'd0);
    cyc(); check_word("3w A", c_a, 4'd0);
    cyc(); check_word("3w B", c_b, 4'd1);
    cyc(); check_word("3w C", c_c, 4'd2);
    cyc();
    check("3w halt state", 32'(state_o), 32'd3);
    check("3w halt instr", 32'(instruction), 32'(c_nop));
    check("3w halt valid", 32'(instr_valid), 32'd0);
    check("3w halt pc", 32'(pc), 32'd2);

    // Four-word program with hold on B; stray load_valid while running.
    load_req = 1'b1;
    cyc();
    load_req = 1'b0;
    check("4w load state", 32'(state_o), 32'd1);
    check("4w len cleared", 32'(prog_len), 32'd0);
    load_word(c_a2, 1'b0);
    load_word(c_b2, 1'b0);
    load_word(c_c2, 1'b0);
    load_word(c_d2, 1'b1);
    check("4w len", 32'(prog_len), 32'd4);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); check_word("4w A", c_a2, 4'd0);
    load_valid = 1'b1;
    load_data  = c_bad;
    load_last  = 1'b1;
    cyc(); check_word("4w B", c_b2, 4'd1);
    check("run ready", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    load_last  = 1'b0;
    hold = 1'b1;
    cyc(); check_word("4w B hold1", c_b2, 4'd1);
    cyc(); check_word("4w B hold2", c_b2, 4'd1);
    check("hold state", 32'(state_o), 32'd2);
    hold = 1'b0;
    cyc(); check_word("4w C", c_c2, 4'd2);
    cyc(); check_word("4w D", c_d2, 4'd3);
    cyc();
    check("4w halt state", 32'(state_o), 32'd3);
    check("4w halt pc", 32'(pc), 32'd3);

    // Rerun shows the RAM untouched by the stray write.
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); check_word("rerun A", c_a2, 4'd0);
    cyc(); check_word("rerun B", c_b2, 4'd1);
    cyc(); check_word("rerun C", c_c2, 4'd2);
    cyc(); check_word("rerun D", c_d2, 4'd3);
    cyc();
    check("rerun halt", 32'(state_o), 32'd3);

    // Overflow: eighteen words, no load_last.
    load_req = 1'b1;
    cyc();
    load_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_word({4'h5, 8'(i), 8'hA5}, 1'b0);
    end
    check("ovf state", 32'(state_o), 32'd0);
    check("ovf err", 32'(load_err), 32'd1);
    check("ovf len", 32'(prog_len), 32'd16);
    check("ovf ready", 32'(load_ready), 32'd0);
    load_word(c_bad, 1'b0);
    load_word(c_bad, 1'b0);
    check("ovf extra state", 32'(state_o), 32'd0);
    check("ovf extra len", 32'(prog_len), 32'd16);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      check_word($sformatf("ovf w%0d", i), {4'h5, 8'(i), 8'hA5}, 4'(i));
    end
    cyc();
    check("ovf halt state", 32'(state_o), 32'd3);
    check("ovf halt pc", 32'(pc), 32'd15);
    check("ovf err kept", 32'(load_err), 32'd1);

    // Asynchronous reset at pc=2 during a run.
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    check("pre-rst pc", 32'(pc), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("async state", 32'(state_o), 32'd0);
    check("async instr", 32'(instruction), 32'(c_nop));
    check("async valid", 32'(instr_valid), 32'd0);
    check("async pc", 32'(pc), 32'd0);
    check("async len", 32'(prog_len), 32'd0);
    check("async err", 32'(load_err), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("post-rst start", 32'(state_o), 32'd0);
    cyc();
    check("post-rst valid", 32'(instr_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_loader.md
Name: instr_fetch_loader

Overview:
Instruction-fetch stage that sits directly upstream of the four-register processor core and replaces the fixed-program fetch block. It holds a loadable program RAM that is filled over a valid/ready word stream. It then steps a program counter through the stored program and presents one 20-bit instruction per cycle, as {op[3:0], first[7:0], second[7:0]}. When the fetch is not running, it drives NOP words so the core never writes its registers.

Parameters:
DEPTH, 16, number of program words in the RAM; must be a power of two, at least 2.
ADDR_W, 4, equal to log2(DEPTH); width of the pc and write pointer.
INSTR_W, 20, instruction word width.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
load_req  in  1  one-cycle pulse that requests LOAD mode.
load_valid  in  1  the load word is valid.
load_data  in  INSTR_W  program word.
load_last  in  1  marks the final word of the program.
load_ready  out  1  high only in LOAD.
start  in  1  one-cycle pulse that begins execution from pc=0.
hold  in  1  freezes pc and the instruction output while in RUN.
instruction  out  INSTR_W  registered instruction sent to the core.
instr_valid  out  1  high when instruction comes from RAM.
pc  out  ADDR_W  address of the word currently on instruction.
prog_len  out  ADDR_W+1  number of words loaded, range 0..DEPTH.
state_o  out  2  current state: IDLE=0, LOAD=1, RUN=2, HALT=3.
load_err  out  1  sticky flag; a load overflowed.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; pc=0; wr_ptr=0; prog_len=0; load_err=0.
  - instruction=NOP_WORD; instr_valid=0.
  - RAM contents are not cleared.
- NOP_WORD is {OP_NULL, 16'h0000}.
  - Outside RUN: instruction=NOP_WORD and instr_valid=0 on every cycle.
- IDLE or HALT, on load_req:
  - go to LOAD; wr_ptr=0; prog_len=0; load_err=0.
  - load_req outranks start when both arrive in the same cycle.
- LOAD:
  - A word is accepted on a cycle where load_valid and load_ready are both high.
  - An accepted word is written to mem[wr_ptr], then wr_ptr increments.
  - Accepted with load_last=1: prog_len=wr_ptr+1; go to IDLE.
  - Accepted at wr_ptr=DEPTH-1 with load_last=0: prog_len=DEPTH; load_err=1; go to IDLE. Later words are not accepted.
  - start and hold are ignored in LOAD.
- IDLE or HALT, on start:
  - prog_len=0: start is ignored and the state stays put.
  - prog_len>0: go to RUN with pc=0.
  - The first RAM word appears on instruction on the next rising edge after entry (1-cycle read latency).
- RUN, without hold, on each clock:
  - instruction <= mem[pc]; instr_valid <= 1; pc advances.
- RUN, end of program:
  - The cycle that fetches address prog_len-1 is the last fetch.
  - On the next edge: state=HALT; instruction=NOP_WORD; instr_valid=0; pc holds prog_len-1.
  - Each word is presented for exactly one cycle, except while hold is asserted.
- RUN with hold=1:
  - pc, instruction and instr_valid keep their values.
  - Release resumes with no word lost or duplicated.
- Counters: the pc never wraps; the HALT transition happens before any wrap.
- load_valid outside LOAD is ignored, and load_ready=0.
- Reset mid-LOAD or mid-RUN aborts at once to IDLE. The program must be reloaded (prog_len=0).

Decomposition:
- Shared package / define header:
  - OP_NULL and the other opcode constants.
  - NOP_WORD.
  - State encodings ST_IDLE, ST_LOAD, ST_RUN, ST_HALT.
  - INSTR_W.
- One sub-module, prog_ram:
  - DEPTH x INSTR_W.
  - Synchronous write port, registered read port.
  - No reset on the array.
- The FSM, pointers and output mux live in instr_fetch_loader.

Test Plan:
- Reset check: hold reset=0 for 3 cycles, then release.
  - Required: state_o=0, instruction=NOP_WORD, instr_valid=0, pc=0, prog_len=0.
- Load and run 3 words:
  - Stimulus: load_req, then 3 words A, B, C with load_last on C, then start.
  - Required: prog_len=3; instruction shows A, B, C on consecutive cycles with instr_valid=1; then HALT, NOP_WORD, pc=2.
- Hold mid-run:
  - Stimulus: 4-word program; assert hold for 2 cycles while B is on the output.
  - Required: B stays for 3 cycles total, then C, then D; no word lost or duplicated.
- Overflow with DEPTH=16:
  - Stimulus: load_req, then 18 words with no load_last.
  - Required: 16 words accepted; load_err=1; prog_len=16; load_ready=0 after the 16th; state returns to IDLE.
- Ignored or overridden control:
  - start with prog_len=0: state stays IDLE.
  - load_req and start in the same cycle: state goes to LOAD.
  - load_valid pulses during RUN: RAM is unchanged and load_ready=0.
- Reset mid-run:
  - Stimulus: pull reset low asynchronously while pc=2 in RUN.
  - Required: outputs go to reset values immediately, without waiting for clk; start after release is ignored because prog_len=0.
